// File: rtl/word_assembler.sv
// Packs DATA_W-wide lanes into an NLANES-wide word with per-lane keep bits.
// A word closes when it fills, on in_last, or on flush, then is held until taken.
module word_assembler #(
  parameter int DATA_W    = 8,
  parameter int NLANES    = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W*NLANES-1:0]   out_data,
  output logic [NLANES-1:0]          out_keep,
  output logic [$clog2(NLANES+1)-1:0] lane_cnt
);

  localparam int CNT_W = $clog2(NLANES + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                     r_state, w_state_next;
  logic [DATA_W*NLANES-1:0]   r_data, w_data_next;
  logic [NLANES-1:0]          r_keep, w_keep_next;
  logic [CNT_W-1:0]           r_cnt, w_cnt_next;
  logic [CNT_W-1:0]           w_cnt_inc;
  logic [CNT_W-1:0]           w_pos;
  logic                       w_xfer;

  assign in_ready  = (r_state == FILL);
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign out_keep  = r_keep;
  assign lane_cnt  = r_cnt;

  assign w_xfer    = in_valid && in_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Lane slot for the incoming transfer depends on fill direction.
  assign w_pos     = (MSB_FIRST != 0) ? (CNT_W'(NLANES - 1) - r_cnt) : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_data  <= '0;
      r_keep  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_keep  <= w_keep_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_keep_next  = r_keep;
    w_cnt_next   = r_cnt;
    case (r_state)
      FILL: begin
        if (w_xfer) begin
          for (int i = 0; i < NLANES; i++) begin
            if (CNT_W'(i) == w_pos) begin
              w_data_next[i*DATA_W +: DATA_W] = in_data;
              w_keep_next[i]                  = 1'b1;
            end
          end
          w_cnt_next = w_cnt_inc;
          // A flush alongside a transfer closes the word with that lane included.
          if ((w_cnt_inc == CNT_W'(NLANES)) || in_last || flush) begin
            w_state_next = HOLD;
          end
        end else if (flush && (r_cnt != '0)) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_next = FILL;
          w_data_next  = '0;
          w_keep_next  = '0;
          w_cnt_next   = '0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench for word_assembler: LSB-first and MSB-first instances share stimulus.
module tb_word_assembler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        flush;
  logic        out_ready;

  logic        l_in_ready, l_out_valid;
  logic [31:0] l_out_data;
  logic [3:0]  l_out_keep;
  logic [2:0]  l_lane_cnt;

  logic        m_in_ready, m_out_valid;
  logic [31:0] m_out_data;
  logic [3:0]  m_out_keep;
  logic [2:0]  m_lane_cnt;

  int checks = 0;
  int errors = 0;

  word_assembler #(.DATA_W(8), .NLANES(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .in_last(in_last), .flush(flush),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
    .out_keep(l_out_keep), .lane_cnt(l_lane_cnt)
  );

  word_assembler #(.DATA_W(8), .NLANES(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .in_last(in_last), .flush(flush),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
    .out_keep(m_out_keep), .lane_cnt(m_lane_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                     input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, l_out_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, l_in_ready}, 32'd1);
    chk({tag, "_data"},  l_out_data, 32'h0);
    chk({tag, "_keep"},  {28'd0, l_out_keep}, 32'h0);
    chk({tag, "_cnt"},   {29'd0, l_lane_cnt}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_idle("reset");
    rst_n = 1'b1;

    // Full word, consumer ready.
    cyc(1, 8'h11, 0, 0, 1);
    chk("full_cnt1", {29'd0, l_lane_cnt}, 32'd1);
    cyc(1, 8'h22, 0, 0, 1);
    cyc(1, 8'h33, 0, 0, 1);
    chk("full_not_yet", {31'd0, l_out_valid}, 32'd0);
    cyc(1, 8'h44, 0, 0, 1);
    $display("txn full_word lsb=%h msb=%h keep=%b", l_out_data, m_out_data, l_out_keep);
    chk("full_valid", {31'd0, l_out_valid}, 32'd1);
    chk("full_ready_low", {31'd0, l_in_ready}, 32'd0);
    chk("full_data", l_out_data, 32'h44332211);
    chk("full_keep", {28'd0, l_out_keep}, 32'hF);
    chk("msb_data", m_out_data, 32'h11223344);
    chk("msb_keep", {28'd0, m_out_keep}, 32'hF);
    cyc(0, 8'h00, 0, 0, 1);
    chk_idle("full_after");

    // Early close with in_last.
    cyc(1, 8'hAA, 0, 0, 0);
    cyc(1, 8'hBB, 1, 0, 0);
    $display("txn early_close data=%h keep=%b cnt=%0d", l_out_data, l_out_keep, l_lane_cnt);
    chk("early_valid", {31'd0, l_out_valid}, 32'd1);
    chk("early_data", l_out_data, 32'h0000BBAA);
    chk("early_keep", {28'd0, l_out_keep}, 32'h3);
    chk("early_cnt", {29'd0, l_lane_cnt}, 32'd2);
    chk("msb_early_data", m_out_data, 32'hAABB0000);
    cyc(0, 8'h00, 0, 0, 1);
    chk_idle("early_after");

    // Backpressure: HOLD ignores in_valid, in_last and flush.
    cyc(1, 8'h10, 0, 0, 0);
    cyc(1, 8'h20, 0, 0, 0);
    cyc(1, 8'h30, 0, 0, 0);
    cyc(1, 8'h40, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 8'hFF, 1, 1, 0);
      $display("txn backpressure cycle=%0d data=%h in_ready=%b", k, l_out_data, l_in_ready);
      chk("bp_data", l_out_data, 32'h40302010);
      chk("bp_ready", {31'd0, l_in_ready}, 32'd0);
      chk("bp_valid", {31'd0, l_out_valid}, 32'd1);
    end
    chk("bp_cnt", {29'd0, l_lane_cnt}, 32'd4);
    cyc(0, 8'h00, 0, 0, 1);
    chk_idle("bp_after");

    // Flush with nothing accepted is ignored; in_last without in_valid is ignored.
    cyc(0, 8'h00, 0, 1, 0);
    chk_idle("flush_empty");
    cyc(0, 8'h99, 1, 0, 0);
    chk_idle("last_novalid");

    // Flush coinciding with a transfer.
    cyc(1, 8'h5A, 0, 1, 0);
    $display("txn flush_xfer data=%h keep=%b", l_out_data, l_out_keep);
    chk("flushx_valid", {31'd0, l_out_valid}, 32'd1);
    chk("flushx_data", l_out_data, 32'h0000005A);
    chk("flushx_keep", {28'd0, l_out_keep}, 32'h1);
    cyc(0, 8'h00, 0, 0, 1);

    // Flush of a partial word on a later cycle.
    cyc(1, 8'h77, 0, 0, 0);
    chk("flushp_pre", {31'd0, l_out_valid}, 32'd0);
    cyc(0, 8'h00, 0, 1, 0);
    $display("txn flush_partial data=%h keep=%b", l_out_data, l_out_keep);
    chk("flushp_valid", {31'd0, l_out_valid}, 32'd1);
    chk("flushp_data", l_out_data, 32'h00000077);
    chk("flushp_keep", {28'd0, l_out_keep}, 32'h1);
    chk("flushp_cnt", {29'd0, l_lane_cnt}, 32'd1);
    cyc(0, 8'h00, 0, 0, 1);

    // Reset mid-word: outputs clear without waiting for a clock edge.
    cyc(1, 8'hC1, 0, 0, 0);
    cyc(1, 8'hC2, 0, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    $display("txn reset_midword cnt=%0d data=%h", l_lane_cnt, l_out_data);
    chk_idle("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while holding a word.
    cyc(1, 8'hD1, 0, 0, 0);
    cyc(1, 8'hD2, 0, 0, 0);
    cyc(1, 8'hD3, 0, 0, 0);
    cyc(1, 8'hD4, 0, 0, 0);
    chk("rst_hold_pre", {31'd0, l_out_valid}, 32'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    $display("txn reset_hold valid=%b data=%h", l_out_valid, l_out_data);
    chk_idle("rst_hold");
    chk("rst_hold_msb", m_out_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean word after reset.
    cyc(1, 8'h01, 0, 0, 0);
    cyc(1, 8'h02, 0, 0, 0);
    cyc(1, 8'h03, 0, 0, 0);
    cyc(1, 8'h04, 0, 0, 0);
    $display("txn post_reset data=%h keep=%b", l_out_data, l_out_keep);
    chk("post_valid", {31'd0, l_out_valid}, 32'd1);
    chk("post_data", l_out_data, 32'h04030201);
    chk("post_keep", {28'd0, l_out_keep}, 32'hF);
    chk("post_msb", m_out_data, 32'h01020304);
    cyc(0, 8'h00, 0, 0, 1);
    chk_idle("post_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
